gol_engine: RTL and testbench

Parametrised Conway's Game of Life engine that owns the board register and computes one full generation per clock. It generalises the fixed 8x8 single-step core to a configurable ROWS x COLS board. It adds selectable toroidal or dead-edge boundaries, single-step and free-run modes, a generation counter with an optional limit, and stable/extinct detection that halts the run. The block sits between the seed/control source and the display/readout logic.

---
 rtl/gol_pkg.sv | 16 +
 rtl/gol_next_gen.sv | 70 +++++++
 rtl/gol_engine.sv | 139 +++++++++++++
 tb/tb_gol_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game of Life engine: FSM state encoding
// and the (row, col) to board-bit mapping.
package gol_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } gol_state_e;

    // Row 0 sits in the MSBs; column 0 is the MSB of each row.
    function automatic int cell_index(input int r, input int c, input int rows, input int cols);
        return (rows - 1 - r) * cols + (cols - 1 - c);
    endfunction

endpackage

// File: rtl/gol_next_gen.sv
// Combinational next-generation computation for a ROWS x COLS board with
// selectable toroidal or dead-edge boundaries.
module gol_next_gen
    import gol_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic [ROWS*COLS-1:0] board,
    input  logic                 wrap,
    output logic [ROWS*COLS-1:0] next
);

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            // Neighbour coordinates are computed toroidally; edge masks kill
            // the wrapped ones when wrap is low.
            localparam int RU = (gr == 0) ? ROWS - 1 : gr - 1;
            localparam int RD = (gr == ROWS - 1) ? 0 : gr + 1;
            localparam int CL = (gc == 0) ? COLS - 1 : gc - 1;
            localparam int CR = (gc == COLS - 1) ? 0 : gc + 1;
            localparam logic EDGE_T = (gr == 0);
            localparam logic EDGE_B = (gr == ROWS - 1);
            localparam logic EDGE_L = (gc == 0);
            localparam logic EDGE_R = (gc == COLS - 1);

            localparam int I_SELF = cell_index(gr, gc, ROWS, COLS);
            localparam int I_UL   = cell_index(RU, CL, ROWS, COLS);
            localparam int I_U    = cell_index(RU, gc, ROWS, COLS);
            localparam int I_UR   = cell_index(RU, CR, ROWS, COLS);
            localparam int I_L    = cell_index(gr, CL, ROWS, COLS);
            localparam int I_R    = cell_index(gr, CR, ROWS, COLS);
            localparam int I_DL   = cell_index(RD, CL, ROWS, COLS);
            localparam int I_D    = cell_index(RD, gc, ROWS, COLS);
            localparam int I_DR   = cell_index(RD, CR, ROWS, COLS);

            logic       ok_u_s;
            logic       ok_d_s;
            logic       ok_l_s;
            logic       ok_r_s;
            logic [7:0] nb_s;
            logic [3:0] cnt_s;

            assign ok_u_s = wrap | ~EDGE_T;
            assign ok_d_s = wrap | ~EDGE_B;
            assign ok_l_s = wrap | ~EDGE_L;
            assign ok_r_s = wrap | ~EDGE_R;

            assign nb_s[0] = board[I_UL] & ok_u_s & ok_l_s;
            assign nb_s[1] = board[I_U]  & ok_u_s;
            assign nb_s[2] = board[I_UR] & ok_u_s & ok_r_s;
            assign nb_s[3] = board[I_L]  & ok_l_s;
            assign nb_s[4] = board[I_R]  & ok_r_s;
            assign nb_s[5] = board[I_DL] & ok_d_s & ok_l_s;
            assign nb_s[6] = board[I_D]  & ok_d_s;
            assign nb_s[7] = board[I_DR] & ok_d_s & ok_r_s;

            // Live-neighbour population count.
            always_comb begin
                cnt_s = 4'd0;
                for (int k = 0; k < 8; k++) begin
                    cnt_s = cnt_s + {3'd0, nb_s[k]};
                end
            end

            assign next[I_SELF] = (cnt_s == 4'd3) | (board[I_SELF] & (cnt_s == 4'd2));
        end
    end

endmodule

// File: rtl/gol_engine.sv
// Game of Life engine: board register, IDLE/RUN/HALT sequencing, generation
// counter with optional limit, and stable/extinct detection.
module gol_engine
    import gol_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 en,
    input  logic                 step,
    input  logic                 wrap,
    input  logic [GEN_W-1:0]     max_gen,
    output logic [ROWS*COLS-1:0] board,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 valid,
    output logic                 stable,
    output logic                 extinct,
    output logic                 done
);

    localparam int N = ROWS * COLS;

    gol_state_e       state_r;
    gol_state_e       base_nxt_s;
    gol_state_e       commit_nxt_s;
    gol_state_e       state_nxt_s;
    logic [N-1:0]     board_r;
    logic [N-1:0]     next_s;
    logic [GEN_W-1:0] gen_r;
    logic [GEN_W:0]   gen_plus_s;
    logic [GEN_W-1:0] gen_sat_s;
    logic             valid_r;
    logic             stable_r;
    logic             extinct_r;
    logic             done_r;
    logic             commit_s;
    logic             stable_s;
    logic             extinct_s;
    logic             limit_s;

    gol_next_gen #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_next_gen (
        .board (board_r),
        .wrap  (wrap),
        .next  (next_s)
    );

    assign stable_s   = (next_s == board_r);
    assign extinct_s  = (next_s == {N{1'b0}});
    // One extra bit keeps the limit compare correct at saturation.
    assign gen_plus_s = {1'b0, gen_r} + {{GEN_W{1'b0}}, 1'b1};
    assign gen_sat_s  = gen_plus_s[GEN_W] ? gen_r : gen_plus_s[GEN_W-1:0];
    assign limit_s    = (max_gen != {GEN_W{1'b0}}) && (gen_plus_s >= {1'b0, max_gen});

    // Commit decision and next state.
    always_comb begin
        commit_s     = 1'b0;
        base_nxt_s   = state_r;
        commit_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (en || step) begin
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (en) begin
                    commit_s = 1'b1;
                end else begin
                    base_nxt_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                base_nxt_s = ST_HALT;
            end
            default: begin
                base_nxt_s = ST_IDLE;
            end
        endcase

        if (stable_s || extinct_s || limit_s) begin
            commit_nxt_s = ST_HALT;
        end else if (en) begin
            commit_nxt_s = ST_RUN;
        end else begin
            commit_nxt_s = ST_IDLE;
        end

        state_nxt_s = commit_s ? commit_nxt_s : base_nxt_s;
    end

    // State, board, counter and flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            board_r   <= {N{1'b0}};
            gen_r     <= {GEN_W{1'b0}};
            valid_r   <= 1'b0;
            stable_r  <= 1'b0;
            extinct_r <= 1'b0;
            done_r    <= 1'b0;
        end else if (load) begin
            state_r   <= ST_IDLE;
            board_r   <= seed;
            gen_r     <= {GEN_W{1'b0}};
            valid_r   <= 1'b0;
            stable_r  <= 1'b0;
            extinct_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == ST_HALT);
            valid_r <= commit_s;
            if (commit_s) begin
                board_r   <= next_s;
                gen_r     <= gen_sat_s;
                stable_r  <= stable_s;
                extinct_r <= extinct_s;
            end
        end
    end

    assign board     = board_r;
    assign gen_count = gen_r;
    assign valid     = valid_r;
    assign stable    = stable_r;
    assign extinct   = extinct_r;
    assign done      = done_r;

endmodule

// File: tb/tb_gol_engine.sv
// Directed, table-driven bench for gol_engine on the default 8x8 board.
module tb_gol_engine;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int GEN_W = 16;
    localparam int NV    = 10;

    localparam logic [63:0] BLINK_H = 64'h0000_0038_0000_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_1010_1000_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SINGLE  = 64'h0000_0010_0000_0000;
    localparam logic [63:0] EDGE3   = 64'hC100_0000_0000_0000;
    localparam logic [63:0] GLIDER0 = 64'h0020_1070_0000_0000;
    localparam logic [63:0] GLIDER1 = 64'h0000_5030_2000_0000;
    localparam logic [63:0] GLIDER2 = 64'h0000_1050_3000_0000;
    localparam logic [63:0] GLIDER3 = 64'h0000_2018_3000_0000;

    typedef struct packed {
        logic [63:0] seed;
        logic        wrap;
        logic [63:0] exp_board;
        logic        exp_stable;
        logic        exp_extinct;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [63:0]      seed;
    logic             en;
    logic             step;
    logic             wrap;
    logic [GEN_W-1:0] max_gen;
    logic [63:0]      board;
    logic [GEN_W-1:0] gen_count;
    logic             valid;
    logic             stable;
    logic             extinct;
    logic             done;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    gol_engine #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .GEN_W (GEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .en        (en),
        .step      (step),
        .wrap      (wrap),
        .max_gen   (max_gen),
        .board     (board),
        .gen_count (gen_count),
        .valid     (valid),
        .stable    (stable),
        .extinct   (extinct),
        .done      (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        vecs[0] = '{BLINK_H, 1'b0, BLINK_V, 1'b0, 1'b0};
        vecs[1] = '{BLINK_V, 1'b0, BLINK_H, 1'b0, 1'b0};
        vecs[2] = '{GLIDER0, 1'b0, GLIDER1, 1'b0, 1'b0};
        vecs[3] = '{GLIDER1, 1'b0, GLIDER2, 1'b0, 1'b0};
        vecs[4] = '{GLIDER2, 1'b0, GLIDER3, 1'b0, 1'b0};
        vecs[5] = '{EDGE3,   1'b1, 64'h8080_0000_0000_0080, 1'b0, 1'b0};
        vecs[6] = '{EDGE3,   1'b0, 64'h0, 1'b0, 1'b1};
        vecs[7] = '{BLOCK,   1'b0, BLOCK, 1'b1, 1'b0};
        vecs[8] = '{SINGLE,  1'b0, 64'h0, 1'b0, 1'b1};
        vecs[9] = '{64'h0,   1'b1, 64'h0, 1'b1, 1'b1};

        reset = 1'b0; load = 1'b0; seed = 64'h0; en = 1'b0; step = 1'b0;
        wrap = 1'b0; max_gen = 16'd0;
        tick();
        tick();
        chk("rst_board", board, 64'h0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_stable", 64'(stable), 64'd0);
        chk("rst_extinct", 64'(extinct), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        tick();

        // Single-step table.
        for (int i = 0; i < NV; i++) begin
            do_load(vecs[i].seed);
            wrap = vecs[i].wrap;
            step = 1'b1;
            tick();
            step = 1'b0;
            chk($sformatf("v%0d_board", i), board, vecs[i].exp_board);
            chk($sformatf("v%0d_gen", i), 64'(gen_count), 64'd1);
            chk($sformatf("v%0d_valid", i), 64'(valid), 64'd1);
            chk($sformatf("v%0d_stable", i), 64'(stable), 64'(vecs[i].exp_stable));
            chk($sformatf("v%0d_extinct", i), 64'(extinct), 64'(vecs[i].exp_extinct));
            chk($sformatf("v%0d_done", i), 64'(done),
                64'(vecs[i].exp_stable | vecs[i].exp_extinct));
            tick();
            chk($sformatf("v%0d_valid_drop", i), 64'(valid), 64'd0);
        end
        wrap = 1'b0;

        // Blinker: two steps return to seed.
        do_load(BLINK_H);
        step = 1'b1; tick(); step = 1'b0; tick();
        step = 1'b1; tick(); step = 1'b0;
        chk("blink2_board", board, BLINK_H);
        chk("blink2_gen", 64'(gen_count), 64'd2);
        chk("blink2_done", 64'(done), 64'd0);

        // Block under free-run: halts stable, no further pulses.
        do_load(BLOCK);
        en = 1'b1;
        tick();
        chk("block_stable", 64'(stable), 64'd1);
        chk("block_done", 64'(done), 64'd1);
        chk("block_gen", 64'(gen_count), 64'd1);
        chk("block_board", board, BLOCK);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses += int'(valid);
        end
        chk("block_pulses", 64'(pulses), 64'd0);
        chk("block_gen_hold", 64'(gen_count), 64'd1);
        en = 1'b0;

        // Single cell under free-run dies.
        do_load(SINGLE);
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("single_board", board, 64'h0);
        chk("single_extinct", 64'(extinct), 64'd1);
        chk("single_done", 64'(done), 64'd1);
        chk("single_gen", 64'(gen_count), 64'd1);

        // Glider with a limit of three generations.
        max_gen = 16'd3;
        do_load(GLIDER0);
        en = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            pulses += int'(valid);
        end
        chk("glider_pulses", 64'(pulses), 64'd3);
        chk("glider_gen", 64'(gen_count), 64'd3);
        chk("glider_done", 64'(done), 64'd1);
        chk("glider_board", board, GLIDER3);
        // load with en held: load wins, no commit on that edge.
        do_load(GLIDER0);
        chk("reload_gen", 64'(gen_count), 64'd0);
        chk("reload_done", 64'(done), 64'd0);
        chk("reload_valid", 64'(valid), 64'd0);
        chk("reload_board", board, GLIDER0);
        en = 1'b0;
        max_gen = 16'd0;
        tick();

        // Reset in the middle of a run.
        do_load(BLINK_H);
        en = 1'b1;
        tick();
        tick();
        chk("run_gen2", 64'(gen_count), 64'd2);
        reset = 1'b0;
        tick();
        chk("midrst_board", board, 64'h0);
        chk("midrst_gen", 64'(gen_count), 64'd0);
        chk("midrst_flags", 64'({valid, stable, extinct, done}), 64'd0);
        reset = 1'b1;
        en = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("empty_board", board, 64'h0);
        chk("empty_extinct", 64'(extinct), 64'd1);
        chk("empty_stable", 64'(stable), 64'd1);
        chk("empty_gen", 64'(gen_count), 64'd1);

        // RUN -> IDLE on en low, then lower max_gen below gen_count.
        do_load(BLINK_H);
        en = 1'b1;
        tick(); tick(); tick();
        chk("free_gen3", 64'(gen_count), 64'd3);
        en = 1'b0;
        tick();
        chk("idle_gen", 64'(gen_count), 64'd3);
        chk("idle_valid", 64'(valid), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        en = 1'b1;
        tick();
        chk("resume_gen", 64'(gen_count), 64'd4);
        max_gen = 16'd2;
        tick();
        chk("lower_gen", 64'(gen_count), 64'd5);
        chk("lower_done", 64'(done), 64'd1);
        chk("lower_board", board, BLINK_V);
        en = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("halt_gen", 64'(gen_count), 64'd5);
        chk("halt_valid", 64'(valid), 64'd0);
        chk("halt_board", board, BLINK_V);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
